// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, read-word
// bit positions and the memory-mapped register address.
package ps2_rx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int          VALID_BIT = 15;
    localparam int          OVF_BIT   = 14;
    localparam logic [15:0] PS2_REG   = 16'hF000;

    // True when the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle, so the count stays put in that case.
module sync_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || pop);
    assign dout  = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronizes and deglitches the device clock, decodes
// 11-bit frames, queues good bytes and presents them as a 16-bit read word.
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000,
    parameter int DEPTH      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ren,
    output logic [15:0] data_out,
    output logic        frame_err
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    logic              ps2_clk_p0, ps2_clk_p1;
    logic              ps2_data_p0, ps2_data_p1;
    logic              filt_clk, filt_prev;
    logic [FILT_W-1:0] filt_cnt;
    logic              bit_evt;

    ps2_state_t        state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              push;
    logic [7:0]        push_byte;

    logic              ovf;
    logic              ovf_set;
    logic [7:0]        head;
    logic              full, empty;
    logic [15:0]       rd_word;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Glitch filter: the level flips only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (ps2_clk_p1 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                filt_clk <= ps2_clk_p1;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign bit_evt = filt_prev && !filt_clk;

    // Frame decoder with inactivity timeout; push and frame_err are one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_cnt   <= '0;
            push      <= 1'b0;
            push_byte <= '0;
            frame_err <= 1'b0;
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
            if (state != IDLE && !bit_evt && tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                state     <= IDLE;
                tmo_cnt   <= '0;
                frame_err <= 1'b1;
            end else begin
                if (bit_evt || state == IDLE) tmo_cnt <= '0;
                else                          tmo_cnt <= tmo_cnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (bit_evt && !ps2_data_p1) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_evt) begin
                            shift_q <= {ps2_data_p1, shift_q[7:1]};
                            if (bit_cnt == 3'd7) state <= PARITY;
                            else                 bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (bit_evt) begin
                            parity_q <= ps2_data_p1;
                            state    <= STOP;
                        end
                    end
                    STOP: begin
                        if (bit_evt) begin
                            if (ps2_data_p1 && odd_parity({shift_q, parity_q})) begin
                                push      <= 1'b1;
                                push_byte <= shift_q;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (ren),
        .din   (push_byte),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // A pop in the same cycle makes room, so only an unmatched push to a full FIFO overflows.
    assign ovf_set = push && full && !ren;

    // Read word assembled from the FIFO head and the overflow flag.
    always_comb begin
        rd_word            = '0;
        rd_word[VALID_BIT] = !empty;
        rd_word[OVF_BIT]   = ovf;
        rd_word[7:0]       = empty ? 8'h00 : head;
    end

    // Read register holds between ren cycles; overflow clears on read unless set again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            ovf      <= 1'b0;
        end else begin
            if (ren) data_out <= rd_word;
            if (ovf_set)  ovf <= 1'b1;
            else if (ren) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo. The system clock stands for 500 kHz, so a
// 40 us PS/2 bit period is 20 clk cycles (10 high, 10 low).
module tb_ps2_rx_fifo;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic        ren;
    logic [15:0] data_out;
    logic        frame_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_cnt = 0;

    ps2_rx_fifo #(
        .FILTER_LEN (4),
        .TIMEOUT    (TIMEOUT),
        .DEPTH      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ren       (ren),
        .data_out  (data_out),
        .frame_err (frame_err)
    );

    always #1000 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        @(negedge clk) ps2_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_read(output logic [15:0] v);
        @(negedge clk) ren = 1'b1;
        @(negedge clk) ren = 1'b0;
        v = data_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ren = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data_out got=%h want=0000", data_out); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_frame;
        logic [15:0] v;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0);
        do_read(v);
        n_cmp++; if (v !== 16'h801C) begin n_fail++; $display("FAIL single_read got=%h want=801C", v); end
        @(negedge clk);
        n_cmp++; if (data_out !== 16'h801C) begin n_fail++; $display("FAIL single_hold got=%h want=801C", data_out); end
        do_read(v);
        n_cmp++; if (v !== 16'h0000) begin n_fail++; $display("FAIL single_empty got=%h want=0000", v); end
        n_cmp++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL single_no_err got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_parity_err;
        logic [15:0] v;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL parity_err_pulses got=%0d want=1", err_cnt - e0); end
        do_read(v);
        n_cmp++; if (v !== 16'h0000) begin n_fail++; $display("FAIL parity_fifo_empty got=%h want=0000", v); end
    endtask

    task automatic test_overflow;
        logic [15:0] v;
        logic [15:0] exp;
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0);
        for (int i = 1; i <= 17; i++) begin
            do_read(v);
            if (i == 1)       exp = 16'hC001;
            else if (i <= 16) exp = 16'h8000 | 16'(i);
            else              exp = 16'h0000;
            n_cmp++; if (v !== exp) begin n_fail++; $display("FAIL overflow_read%0d got=%h want=%h", i, v, exp); end
        end
    endtask

    task automatic test_timeout;
        logic [15:0] v;
        int e0;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk) ps2_data = 1'b1;
        repeat (TIMEOUT + 10) @(negedge clk);
        n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL timeout_err_pulses got=%0d want=1", err_cnt - e0); end
        send_frame(8'h5A, 1'b0);
        do_read(v);
        n_cmp++; if (v !== 16'h805A) begin n_fail++; $display("FAIL timeout_next_frame got=%h want=805A", v); end
        n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL timeout_extra_err got=%0d want=1", err_cnt - e0); end
    endtask

    task automatic test_glitch;
        logic [15:0] v;
        int e0;
        e0 = err_cnt;
        @(negedge clk) ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL glitch_err got=%0d want=0", err_cnt - e0); end
        send_frame(8'h33, 1'b0);
        do_read(v);
        n_cmp++; if (v !== 16'h8033) begin n_fail++; $display("FAIL glitch_next_frame got=%h want=8033", v); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        logic [15:0] exp;
        bit seen;
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b0);
        seen = 1'b0;
        fork
            send_frame(8'h50, 1'b0);
            begin
                for (int c = 0; c < 400 && !seen; c++) begin
                    @(negedge clk);
                    if (dut.push === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    ren = 1'b1;
                    @(negedge clk) ren = 1'b0;
                    v = data_out;
                end else begin
                    v = 16'hxxxx;
                end
            end
        join
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL b2b_push_seen got=0 want=1"); end
        n_cmp++; if (v !== 16'h8040) begin n_fail++; $display("FAIL b2b_coincident_read got=%h want=8040", v); end
        for (int i = 1; i <= 17; i++) begin
            do_read(v);
            if (i <= 16) exp = 16'h8040 + 16'(i);
            else         exp = 16'h0000;
            n_cmp++; if (v !== exp) begin n_fail++; $display("FAIL b2b_read%0d got=%h want=%h", i, v, exp); end
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] v;
        send_frame(8'h77, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        n_cmp++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL midreset_data_out got=%h want=0000", data_out); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_frame_err got=%b want=0", frame_err); end
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_read(v);
        n_cmp++; if (v !== 16'h0000) begin n_fail++; $display("FAIL midreset_fifo_cleared got=%h want=0000", v); end
        send_frame(8'h29, 1'b0);
        do_read(v);
        n_cmp++; if (v !== 16'h8029) begin n_fail++; $display("FAIL midreset_next_frame got=%h want=8029", v); end
        do_read(v);
        n_cmp++; if (v !== 16'h0000) begin n_fail++; $display("FAIL midreset_no_extra got=%h want=0000", v); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
